// File: rtl/piso_bit_serializer.sv
// piso_bit_serializer: parallel-in/serial-out stage feeding serial sequence
// detectors. Accepts a WIDTH-bit word over valid/ready and emits it one bit
// per enabled clock, with back-to-back reload on the last enabled bit so the
// downstream detector sees a gapless bit stream.
//
// Ports:
//   clk        - clock, rising edge
//   rst        - asynchronous active-low reset (0 = in reset)
//   din        - parallel word to serialize
//   din_valid  - din offered this cycle
//   din_ready  - word accepted at this edge if din_valid=1 (combinational)
//   shift_en   - advance one bit this cycle; 0 holds the current bit
//   sout       - current serial bit
//   sout_valid - sout carries a word bit
//   sout_last  - sout is the final bit of the current word
module piso_bit_serializer #(
  parameter int unsigned WIDTH     = 4,
  parameter bit          MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic             shift_en,
  output logic             sout,
  output logic             sout_valid,
  output logic             sout_last
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_shreg;
  logic [WIDTH-1:0] w_shreg_nxt;
  logic [WIDTH-1:0] w_shreg_shifted;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_last;
  logic             w_accept;

  // State, shift register and bit counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_shreg <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_shreg <= w_shreg_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Shift toward the output end, zero-filling the vacated bit
  assign w_shreg_shifted = MSB_FIRST ? {r_shreg[WIDTH-2:0], 1'b0}
                                     : {1'b0, r_shreg[WIDTH-1:1]};

  assign w_last    = (r_state == SHIFT) && (r_cnt == CNT_W'(WIDTH - 1));
  // Ready on the last enabled bit too, which gives the gapless reload
  assign din_ready = rst && ((r_state == IDLE) || (w_last && shift_en));
  assign w_accept  = din_valid && din_ready;

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    w_shreg_nxt = r_shreg;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_nxt = SHIFT;
          w_shreg_nxt = din;
          w_cnt_nxt   = '0;
        end
      end
      SHIFT: begin
        if (shift_en) begin
          if (!w_last) begin
            w_shreg_nxt = w_shreg_shifted;
            w_cnt_nxt   = r_cnt + CNT_W'(1);
          end else if (w_accept) begin
            w_shreg_nxt = din;
            w_cnt_nxt   = '0;
          end else begin
            w_state_nxt = IDLE;
            w_shreg_nxt = '0;
            w_cnt_nxt   = '0;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_shreg_nxt = '0;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Outputs decoded from registered state
  assign sout_valid = (r_state == SHIFT);
  assign sout_last  = w_last;
  assign sout       = (r_state == SHIFT) &&
                      (MSB_FIRST ? r_shreg[WIDTH-1] : r_shreg[0]);

endmodule

// File: tb/tb_piso_bit_serializer.sv
// Directed bench for piso_bit_serializer (WIDTH=4). dut0 is LSB-first and is
// checked against the vector table; dut1 (MSB-first) shares all inputs.
module tb_piso_bit_serializer;

  localparam int unsigned W = 4;

  logic         clk;
  logic         rst;
  logic [W-1:0] din;
  logic         din_valid;
  logic         shift_en;
  logic         din_ready0, sout0, sout_valid0, sout_last0;
  logic         din_ready1, sout1, sout_valid1, sout_last1;

  int n_cmp;
  int n_err;

  typedef struct {
    string        name;
    logic         rst;
    logic [W-1:0] din;
    logic         din_valid;
    logic         shift_en;
    logic         exp_sout;
    logic         exp_valid;
    logic         exp_last;
    logic         exp_ready;
  } vec_t;

  vec_t vecs[$];

  piso_bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut0 (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
    .din_ready(din_ready0), .shift_en(shift_en), .sout(sout0),
    .sout_valid(sout_valid0), .sout_last(sout_last0)
  );

  piso_bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut1 (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
    .din_ready(din_ready1), .shift_en(shift_en), .sout(sout1),
    .sout_valid(sout_valid1), .sout_last(sout_last1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_dut0(input string name, input logic so, input logic sv,
                          input logic sl, input logic sr);
    chk({name, ".sout"}, sout0, so);
    chk({name, ".sout_valid"}, sout_valid0, sv);
    chk({name, ".sout_last"}, sout_last0, sl);
    chk({name, ".din_ready"}, din_ready0, sr);
  endtask

  task automatic add(input string name, input logic r, input logic [W-1:0] d,
                     input logic v, input logic s, input logic so,
                     input logic sv, input logic sl, input logic sr);
    vec_t t;
    t.name = name; t.rst = r; t.din = d; t.din_valid = v; t.shift_en = s;
    t.exp_sout = so; t.exp_valid = sv; t.exp_last = sl; t.exp_ready = sr;
    vecs.push_back(t);
  endtask

  // Drive at the falling edge, check 1ns later, well before the rising edge
  task automatic drive(input logic r, input logic [W-1:0] d, input logic v,
                       input logic s);
    @(negedge clk);
    rst = r; din = d; din_valid = v; shift_en = s;
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b0; din = 4'b1111; din_valid = 1'b1; shift_en = 1'b1;

    // Single word 1001, LSB first: 1,0,0,1
    add("single.acc", 1, 4'b1001, 1, 1, 0, 0, 0, 1);
    add("single.b1",  1, 4'b0000, 0, 1, 1, 1, 0, 0);
    add("single.b2",  1, 4'b0000, 0, 1, 0, 1, 0, 0);
    add("single.b3",  1, 4'b0000, 0, 1, 0, 1, 0, 0);
    add("single.b4",  1, 4'b0000, 0, 1, 1, 1, 1, 1);
    add("single.idl", 1, 4'b0000, 0, 1, 0, 0, 0, 1);
    // Back-to-back 1001 then 0110: 1,0,0,1,0,1,1,0 without a gap
    add("b2b.acc",    1, 4'b1001, 1, 1, 0, 0, 0, 1);
    add("b2b.b1",     1, 4'b0110, 1, 1, 1, 1, 0, 0);
    add("b2b.b2",     1, 4'b0110, 1, 1, 0, 1, 0, 0);
    add("b2b.b3",     1, 4'b0110, 1, 1, 0, 1, 0, 0);
    add("b2b.b4",     1, 4'b0110, 1, 1, 1, 1, 1, 1);
    add("b2b.b5",     1, 4'b0000, 0, 1, 0, 1, 0, 0);
    add("b2b.b6",     1, 4'b0000, 0, 1, 1, 1, 0, 0);
    add("b2b.b7",     1, 4'b0000, 0, 1, 1, 1, 0, 0);
    add("b2b.b8",     1, 4'b0000, 0, 1, 0, 1, 1, 1);
    add("b2b.idl",    1, 4'b0000, 0, 1, 0, 0, 0, 1);
    // Stall on bit 2 for 3 cycles, then a stall on the last bit
    add("stall.acc",  1, 4'b1001, 1, 1, 0, 0, 0, 1);
    add("stall.b1",   1, 4'b0000, 0, 1, 1, 1, 0, 0);
    add("stall.s1",   1, 4'b0000, 0, 0, 0, 1, 0, 0);
    add("stall.s2",   1, 4'b0000, 0, 0, 0, 1, 0, 0);
    add("stall.s3",   1, 4'b0000, 0, 0, 0, 1, 0, 0);
    add("stall.b2",   1, 4'b0000, 0, 1, 0, 1, 0, 0);
    add("stall.b3",   1, 4'b0000, 0, 1, 0, 1, 0, 0);
    add("stall.b4h",  1, 4'b0110, 1, 0, 1, 1, 1, 0);
    add("stall.b4",   1, 4'b0000, 0, 1, 1, 1, 1, 1);
    add("stall.idl",  1, 4'b0000, 0, 1, 0, 0, 0, 1);
    // Busy drop: 1111 offered while 1001 shifts, taken only on the last bit
    add("busy.acc",   1, 4'b1001, 1, 1, 0, 0, 0, 1);
    add("busy.b1",    1, 4'b1111, 1, 1, 1, 1, 0, 0);
    add("busy.b2",    1, 4'b1111, 1, 1, 0, 1, 0, 0);
    add("busy.b3",    1, 4'b1111, 1, 1, 0, 1, 0, 0);
    add("busy.b4",    1, 4'b1111, 1, 1, 1, 1, 1, 1);
    add("busy.n1",    1, 4'b0000, 0, 1, 1, 1, 0, 0);
    add("busy.n2",    1, 4'b0000, 0, 1, 1, 1, 0, 0);
    add("busy.n3",    1, 4'b0000, 0, 1, 1, 1, 0, 0);
    add("busy.n4",    1, 4'b0000, 0, 1, 1, 1, 1, 1);
    add("busy.idl",   1, 4'b0000, 0, 1, 0, 0, 0, 1);
    // shift_en is ignored in IDLE: accept with shift_en=0, 0011 -> 1,1,0,0
    add("idsen.acc",  1, 4'b0011, 1, 0, 0, 0, 0, 1);
    add("idsen.b1",   1, 4'b0000, 0, 1, 1, 1, 0, 0);
    add("idsen.b2",   1, 4'b0000, 0, 1, 1, 1, 0, 0);
    add("idsen.b3",   1, 4'b0000, 0, 1, 0, 1, 0, 0);
    add("idsen.b4",   1, 4'b0000, 0, 1, 0, 1, 1, 1);
    add("idsen.idl",  1, 4'b0000, 0, 1, 0, 0, 0, 1);

    // Reset state, asynchronous and with din_valid high
    #2;
    chk_dut0("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("reset.dut1_valid", sout_valid1, 1'b0);
    drive(1'b0, 4'b1111, 1'b1, 1'b1);
    chk_dut0("reset.hold", 1'b0, 1'b0, 1'b0, 1'b0);

    // Table vectors
    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].din, vecs[i].din_valid, vecs[i].shift_en);
      chk_dut0(vecs[i].name, vecs[i].exp_sout, vecs[i].exp_valid,
               vecs[i].exp_last, vecs[i].exp_ready);
    end

    // Bit order: 1100 -> MSB-first 1,1,0,0 and LSB-first 0,0,1,1
    begin
      logic [3:0] exp_msb;
      logic [3:0] exp_lsb;
      exp_msb = 4'b1100;
      exp_lsb = 4'b0011;
      drive(1'b1, 4'b1100, 1'b1, 1'b1);
      chk("msb.acc_ready", din_ready1, 1'b1);
      for (int b = 0; b < 4; b++) begin
        drive(1'b1, 4'b0000, 1'b0, 1'b1);
        chk("msb.sout", sout1, exp_msb[3-b]);
        chk("msb.lsb_sout", sout0, exp_lsb[3-b]);
        chk("msb.last", sout_last1, (b == 3));
      end
      drive(1'b1, 4'b0000, 1'b0, 1'b1);
      chk("msb.idle_valid", sout_valid1, 1'b0);
    end

    // Async reset between edges during bit 2, then a clean word
    drive(1'b1, 4'b1001, 1'b1, 1'b1);
    drive(1'b1, 4'b0000, 1'b0, 1'b1);
    chk("arst.b1_sout", sout0, 1'b1);
    drive(1'b1, 4'b0000, 1'b1, 1'b1);
    chk("arst.b2_valid", sout_valid0, 1'b1);
    #1 rst = 1'b0;
    #1;
    chk_dut0("arst.mid", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("arst.dut1_valid", sout_valid1, 1'b0);
    drive(1'b0, 4'b0000, 1'b1, 1'b1);
    chk_dut0("arst.held", 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 4'b1001, 1'b1, 1'b1);
    chk_dut0("arst.idle", 1'b0, 1'b0, 1'b0, 1'b1);
    begin
      logic [3:0] exp_bits;
      exp_bits = 4'b1001;
      for (int b = 0; b < 4; b++) begin
        drive(1'b1, 4'b0000, 1'b0, 1'b1);
        chk_dut0("arst.word", exp_bits[b], 1'b1, (b == 3), (b == 3));
      end
      drive(1'b1, 4'b0000, 1'b0, 1'b1);
      chk_dut0("arst.end", 1'b0, 1'b0, 1'b0, 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/piso_bit_serializer.md
Name: piso_bit_serializer

Overview:
Parallel-in/serial-out stage that sits directly upstream of the team's serial sequence detectors, such as the 1001 Mealy detector.
- Accepts a WIDTH-bit word over a valid/ready handshake.
- Emits the word one bit per enabled clock on a serial output, with a bit-valid and a last-bit flag.
- Supports back-to-back words with no bubble, so the detector sees a continuous bit stream.

Parameters:
WIDTH, 4, word width in bits; legal range WIDTH >= 2.
MSB_FIRST, 0, 0 = shift out din[0] first (LSB-first); 1 = shift out din[WIDTH-1] first.

Ports:
clk  input  1  clock; all state changes on its rising edge.
rst  input  1  reset, asynchronous, active-low (0 = in reset).
din  input  WIDTH  parallel word to serialize.
din_valid  input  1  din is offered this cycle.
din_ready  output  1  block accepts din at this rising edge if din_valid=1.
shift_en  input  1  advance one bit this cycle; 0 = hold current bit.
sout  output  1  current serial bit; feeds the detector's serial input.
sout_valid  output  1  sout carries a word bit.
sout_last  output  1  sout is the final bit of the current word.

Behaviour:
- Reset (rst=0, asynchronous, no clock needed):
  - State goes to IDLE; shift register and bit counter clear to 0.
  - sout=0, sout_valid=0, sout_last=0, din_ready=0 (gated by rst).
  - Any in-flight word is discarded.
  - First accept is possible at the first rising edge after rst returns to 1.
- State machine has two states, IDLE and SHIFT; bit counter cnt is $clog2(WIDTH) bits wide.
- din_ready (combinational) = rst && ( IDLE || (SHIFT && cnt==WIDTH-1 && shift_en) ).
- Accept = din_valid && din_ready at a rising edge. On accept: shreg<=din, cnt<=0, state<=SHIFT.
- Outputs are combinational from registers:
  - sout_valid = (state==SHIFT).
  - sout = MSB_FIRST ? shreg[WIDTH-1] : shreg[0] in SHIFT; 0 in IDLE.
  - sout_last = SHIFT && cnt==WIDTH-1.
- Latency: the first bit appears in the cycle after the accept edge.
- In SHIFT with shift_en=1 and cnt<WIDTH-1:
  - shreg shifts toward the output end; the vacated bit fills with 0.
  - cnt increments by 1.
- In SHIFT with shift_en=1 and cnt==WIDTH-1:
  - If an accept also occurs: reload the new word, cnt=0, stay in SHIFT. There is no gap cycle and sout_valid stays 1.
  - Otherwise: state goes to IDLE, shreg clears, cnt goes to 0.
- shift_en=0 in SHIFT: shreg, cnt and all outputs hold. Stalls of any length are legal.
- din_valid while SHIFT and not on the last enabled bit: ignored. din_ready=0 and din is not sampled.
- shift_en is ignored in IDLE.
- Reset asserted mid-word: sout_valid falls asynchronously; partial words are never resumed.
- A word is always emitted as exactly WIDTH enabled cycles with sout_valid=1; sout_last is high for exactly one enabled cycle per word.

Test Plan:
- Single word: WIDTH=4, MSB_FIRST=0, shift_en=1, din=4'b1001 accepted at edge E0.
  - Required: sout=1,0,0,1 in the 4 cycles after E0.
  - sout_last=1 only on the 4th bit; din_ready=0 on bits 1-3 and 1 on bit 4.
  - IDLE with sout_valid=0 after E4.
- Back-to-back: din_valid held 1, words 4'b1001 then 4'b0110.
  - Required: 8 contiguous valid bits 1,0,0,1,0,1,1,0.
  - sout_valid never drops; sout_last high on bits 4 and 8.
- Stall: din=4'b1001, shift_en=0 for 3 cycles while bit 2 is on sout.
  - Required: sout holds 0 with sout_valid=1 through the stall.
  - Word completes in 7 cycles; bit order is unchanged.
- Bit order: MSB_FIRST=1, din=4'b1100 -> sout=1,1,0,0.
- Busy drop: din_valid=1 with din=4'b1111 presented during bit 2 of 4'b1001.
  - Required: din_ready=0 and 4'b1001 completes intact.
  - 4'b1111 is accepted only on the last-bit edge if still held.
- Async reset: rst driven to 0 between clock edges during bit 2.
  - Required: sout_valid, sout and din_ready go to 0 immediately.
  - After rst=1, the block is IDLE and the next word 4'b1001 serializes normally (1,0,0,1).
